timer_dev: RTL and testbench

//   Bus-slave timer device that answers CPU external-bus accesses (Pr* side) routed by the bridge.

---
 rtl/timer_dev.sv | 128 ++++++++++++
 tb/tb_timer_dev.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// timer_dev: bus-slave down-counting timer with CTRL / PRESET / COUNT registers.
// Counts down from PRESET while enabled and raises a maskable interrupt flag
// when the count expires. Supports one-shot and auto-reload operation.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | stopped; COUNT held; moves to LOAD once CTRL.EN is set
//   LOAD   | copies PRESET into COUNT
//   CNT    | decrements COUNT while EN; sets irq_flag on reaching 0
//   INT    | expiry: one-shot clears EN and stops, auto-reload reloads

module timer_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic        w_sel;
  logic [1:0]  w_off;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_reload;

  // Address decode and write strobes
  assign w_sel       = (Addr[31:4] == BASE_ADDR[31:4]);
  assign w_off       = Addr[3:2];
  assign w_wr_ctrl   = WE & w_sel & (w_off == OFF_CTRL);
  assign w_wr_preset = WE & w_sel & (w_off == OFF_PRESET);
  // MODE 2/3 fall back to one-shot
  assign w_reload    = (r_ctrl[2:1] == 2'b01);

  // Interrupt line is the masked flag; both terms are registers
  assign IRQ = r_ctrl[3] & r_irq_flag;

  // Read mux, combinational from the offset regardless of select
  always_comb begin
    RD = 32'h0;
    case (w_off)
      OFF_CTRL:   RD = {28'h0, r_ctrl};
      OFF_PRESET: RD = r_preset;
      OFF_COUNT:  RD = r_count;
      default:    RD = 32'h0;
    endcase
  end

  // PRESET register with per-byte-lane writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_preset <= 32'h0;
    end else if (w_wr_preset) begin
      for (int i = 0; i < 4; i++) begin
        if (BE[i]) r_preset[8*i +: 8] <= WD[8*i +: 8];
      end
    end
  end

  // Timer FSM plus CTRL/COUNT/flag; the bus CTRL write is placed last so it overrides the FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ctrl     <= 4'h0;
      r_count    <= 32'h0;
      r_irq_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_ctrl[0]) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!r_ctrl[0]) begin
            r_state <= S_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            // PRESET of 0 or 1 both expire here; COUNT never wraps
            r_count    <= 32'h0;
            r_irq_flag <= 1'b1;
            r_state    <= S_INT;
          end
        end
        S_INT: begin
          if (w_reload) begin
            r_irq_flag <= 1'b0;
            r_state    <= S_LOAD;
          end else begin
            r_ctrl[0] <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_wr_ctrl) begin
        r_irq_flag <= 1'b0;
        if (BE[0]) r_ctrl <= WD[3:0];
      end
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed scenarios plus randomized bus traffic, every cycle
// compared against a behavioural model of the timer's register/timing rules.

module tb_timer_dev;

  localparam logic [31:0] BASE   = 32'h0000_7f00;
  localparam logic [29:0] BASE_W = 30'h0000_1fc0;  // BASE >> 2
  localparam logic [29:0] OTHER_W = 30'h0000_1fc8; // 0x7f20 >> 2

  logic        clk;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  int n_total = 0;
  int n_bad   = 0;

  timer_dev #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .BE    (BE),
    .WD    (WD),
    .RD    (RD),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model. The timer is described by what it is doing:
  // stopped, about to reload, counting, or just expired.
  localparam int PH_STOP = 0, PH_RELOAD = 1, PH_COUNT = 2, PH_EXPIRED = 3;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_flag;
  int          m_phase;
  bit          m_valid = 0;

  function automatic logic [31:0] m_read(input logic [1:0] off);
    if (off == 2'd0) return {28'h0, m_ctrl};
    if (off == 2'd1) return m_preset;
    if (off == 2'd2) return m_count;
    return 32'h0;
  endfunction

  task automatic m_step(input bit rst, input bit we, input logic [29:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    logic [3:0]  nc;
    logic [31:0] np, nn;
    bit          nf;
    int          nph;
    bit          hit;
    if (rst) begin
      m_ctrl = 0; m_preset = 0; m_count = 0; m_flag = 0; m_phase = PH_STOP;
      return;
    end
    nc = m_ctrl; np = m_preset; nn = m_count; nf = m_flag; nph = m_phase;
    if (m_phase == PH_STOP) begin
      if (m_ctrl[0]) nph = PH_RELOAD;
    end else if (m_phase == PH_RELOAD) begin
      nn = m_preset; nph = PH_COUNT;
    end else if (m_phase == PH_COUNT) begin
      if (!m_ctrl[0]) nph = PH_STOP;
      else if (m_count >= 2) nn = m_count - 1;
      else begin nn = 0; nf = 1; nph = PH_EXPIRED; end
    end else begin
      if (m_ctrl[2:1] == 2'b01) begin nf = 0; nph = PH_RELOAD; end
      else begin nc[0] = 1'b0; nph = PH_STOP; end
    end
    hit = we && (a[29:2] == BASE[31:4]);
    if (hit && a[1:0] == 2'd0) begin
      nf = 0;
      if (be[0]) nc = wd[3:0];
    end
    if (hit && a[1:0] == 2'd1) begin
      for (int i = 0; i < 4; i++) if (be[i]) np[8*i +: 8] = wd[8*i +: 8];
    end
    m_ctrl = nc; m_preset = np; m_count = nn; m_flag = nf; m_phase = nph;
  endtask

  // One bus cycle: drive at negedge, check pre-edge view, clock, advance model
  task automatic cyc(input bit rst, input bit we, input logic [29:0] a,
                     input logic [3:0] be, input logic [31:0] wd);
    @(negedge clk);
    reset = rst; WE = we; Addr = a; BE = be; WD = wd;
    #1;
    if (m_valid) begin
      chk("rd", RD, m_read(a[1:0]));
      chk("irq", {31'h0, IRQ}, {31'h0, m_ctrl[3] & m_flag});
    end
    @(posedge clk);
    m_step(rst, we, a, be, wd);
    if (rst) m_valid = 1;
    #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] wd);
    cyc(0, 1, BASE_W + 30'(off), 4'hF, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, BASE_W + 30'd2, 4'h0, 32'h0);
  endtask

  task automatic peek(input string tag, input logic [1:0] off, input logic [31:0] exp);
    Addr = BASE_W + 30'(off); WE = 0;
    #1;
    chk(tag, RD, exp);
  endtask

  initial begin
    int edges;
    int first_pulse, second_pulse;
    bit prev_irq, wide;
    reset = 1; WE = 0; Addr = 0; BE = 0; WD = 0;

    // 1: one-shot with interrupt
    cyc(1, 0, BASE_W, 4'h0, 32'h0);
    peek("rst_ctrl", 2'd0, 32'h0);
    peek("rst_preset", 2'd1, 32'h0);
    peek("rst_count", 2'd2, 32'h0);
    chk("rst_irq", {31'h0, IRQ}, 32'h0);
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    edges = 0;
    while (!IRQ && edges < 20) begin idle(1); edges++; end
    chk("t1_irq_latency", edges, 32'd7);
    peek("t1_count0", 2'd2, 32'h0);
    idle(1);
    peek("t1_ctrl", 2'd0, 32'h8);
    idle(3);
    chk("t1_irq_held", {31'h0, IRQ}, 32'h1);

    // 2: CTRL write clears the pending interrupt
    wr(2'd0, 32'h8);
    chk("t2_irq_low", {31'h0, IRQ}, 32'h0);
    idle(4);
    peek("t2_count", 2'd2, 32'h0);

    // 3: auto-reload pulses every 5 edges
    cyc(1, 0, BASE_W, 4'h0, 32'h0);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    first_pulse = -1; second_pulse = -1; wide = 0; prev_irq = 0;
    for (int k = 1; k <= 14; k++) begin
      idle(1);
      if (IRQ && prev_irq) wide = 1;
      if (IRQ && first_pulse < 0) first_pulse = k;
      else if (IRQ && second_pulse < 0) second_pulse = k;
      prev_irq = IRQ;
    end
    chk("t3_first_pulse", first_pulse, 32'd5);
    chk("t3_period", second_pulse - first_pulse, 32'd5);
    chk("t3_width", {31'h0, wide}, 32'h0);

    // 4: masked expiry, then CTRL write landing on the expiry cycle
    cyc(1, 0, BASE_W, 4'h0, 32'h0);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    idle(4);
    peek("t4_count0", 2'd2, 32'h0);
    wr(2'd0, 32'h9);
    peek("t4_ctrl_kept", 2'd0, 32'h9);
    chk("t4_irq", {31'h0, IRQ}, 32'h0);

    // 5: reset mid-count, ignored writes
    cyc(1, 0, BASE_W, 4'h0, 32'h0);
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    idle(5);
    peek("t5_count7", 2'd2, 32'd7);
    cyc(1, 0, BASE_W, 4'h0, 32'h0);
    peek("t5_count_rst", 2'd2, 32'h0);
    peek("t5_ctrl_rst", 2'd0, 32'h0);
    chk("t5_irq_rst", {31'h0, IRQ}, 32'h0);
    wr(2'd2, 32'hFFFF);
    cyc(0, 1, OTHER_W + 30'd1, 4'hF, 32'h55);
    peek("t5_count_ro", 2'd2, 32'h0);
    peek("t5_preset_other", 2'd1, 32'h0);

    // 6: byte-lane write
    wr(2'd1, 32'h1122_3344);
    cyc(0, 1, BASE_W + 30'd1, 4'b0010, 32'hAABB_CCDD);
    peek("t6_preset_lane", 2'd1, 32'h1122_CC44);

    // Random traffic against the model
    cyc(1, 0, BASE_W, 4'h0, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      bit          r, w;
      logic [29:0] a;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [1:0]  off;
      r   = ($urandom_range(0, 99) < 2);
      w   = ($urandom_range(0, 99) < 25);
      off = 2'($urandom_range(0, 3));
      a   = (($urandom_range(0, 99) < 85) ? BASE_W : OTHER_W) + 30'(off);
      be  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      if (off == 2'd1) wd = {$urandom_range(0, 1) == 1 ? 24'h0 : 24'($urandom), 8'($urandom_range(0, 7))};
      else wd = {28'($urandom), 4'($urandom)};
      cyc(r, w, a, be, wd);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
